// File: rtl/pwm_pkg.sv
// pwm_pkg: shared servo-PWM constants, state enum and position type for pwm_gen / pwm_capture.
package pwm_pkg;
   localparam int CLK_PER_US      = 50;
   localparam int PWM_MIN_CYC     = 1000 * CLK_PER_US;
   localparam int PWM_FULL_CYC    = 2000 * CLK_PER_US;
   localparam int PWM_GLITCH_CYC  = 500 * CLK_PER_US;
   localparam int PWM_MAX_CYC     = 2500 * CLK_PER_US;
   localparam int PWM_TIMEOUT_CYC = 25000 * CLK_PER_US;
   localparam int PWM_STEP_CYC    = (PWM_FULL_CYC - PWM_MIN_CYC) / 255;
   typedef logic [7:0] position_t;
   typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} pwm_cap_state_t;
   function automatic position_t sat_inc(position_t p);
      return (p == 8'hff) ? p : p + 8'd1;
   endfunction
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchronizer with rise/fall strobes aligned to the synchronized level.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);
   logic s1;
   always_ff @(posedge clk)
      if (!rst_n) begin
         s1 <= 1'b0;
         s <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1 <= d;
         s <= s1;
         rise <= s1 & ~s;
         fall <= ~s1 & s;
      end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: RC servo pulse decoder to 8-bit position with glitch/overlength rejection and loss-of-signal flag.
// Define PWM_CAPTURE_FILTER_EN to average consecutive raw results (one extra cycle of latency).
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int MIN_CYC     = PWM_MIN_CYC,
   parameter int STEP_CYC    = PWM_STEP_CYC,
   parameter int GLITCH_CYC  = PWM_GLITCH_CYC,
   parameter int MAX_CYC     = PWM_MAX_CYC,
   parameter int TIMEOUT_CYC = PWM_TIMEOUT_CYC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_in,
   output logic [7:0] position,
   output logic       valid,
   output logic       pulse_err,
   output logic       signal_lost
);
   localparam int TW = $clog2(TIMEOUT_CYC + 2);
   localparam logic [16:0] W_MIN = 17'(MIN_CYC);
   localparam logic [16:0] W_GL = 17'(GLITCH_CYC);
   localparam logic [16:0] W_MAX = 17'(MAX_CYC);
   localparam logic [16:0] P_LAST = 17'(STEP_CYC - 1);
   localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYC);
   pwm_cap_state_t state, nxt;
   logic s, rise, fall, done, err, vld_n, ph;
   logic [1:0] rdy;
   logic [16:0] w, w_n, pre, pre_n;
   position_t stp, stp_n;
   logic [TW-1:0] cnt;
   pwm_sync_edge sync (.clk(clk), .rst_n(rst_n), .d(pwm_in), .s(s), .rise(rise), .fall(fall));
   // WAIT_LOW ignores s until the synchronizer has refilled after reset (rdy)
   always_comb begin
      nxt = state;
      w_n = w;
      pre_n = pre;
      stp_n = stp;
      done = 1'b0;
      err = 1'b0;
      case (state)
         WAIT_LOW: nxt = (rdy[1] && !s) ? IDLE : WAIT_LOW;
         IDLE: begin
            w_n = rise ? 17'd1 : '0;
            pre_n = '0;
            stp_n = '0;
            nxt = rise ? HIGH : IDLE;
         end
         HIGH: if (fall) begin
            nxt = IDLE;
            done = w >= W_GL;
            err = w < W_GL;
         end else begin
            w_n = (w > W_MAX) ? w : w + 17'd1;
            if (w >= W_MIN) begin
               pre_n = (pre == P_LAST) ? '0 : pre + 17'd1;
               stp_n = (pre == P_LAST) ? sat_inc(stp) : stp;
            end
            if (w == W_MAX) begin
               err = 1'b1;
               nxt = WAIT_LOW;
            end
         end
         default: nxt = WAIT_LOW;
      endcase
   end
   // Counter advances by two every other cycle, so it still tracks elapsed cycles
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= WAIT_LOW;
         w <= '0;
         pre <= '0;
         stp <= '0;
         rdy <= '0;
         valid <= 1'b0;
         pulse_err <= 1'b0;
         cnt <= T_LIM;
         ph <= 1'b0;
      end else begin
         state <= nxt;
         w <= w_n;
         pre <= pre_n;
         stp <= stp_n;
         rdy <= {rdy[0], 1'b1};
         valid <= vld_n;
         pulse_err <= err;
         ph <= vld_n ? 1'b0 : ~ph;
         cnt <= vld_n ? '0 : (ph && cnt < T_LIM) ? cnt + TW'(2) : cnt;
      end
   assign signal_lost = cnt >= T_LIM;
`ifdef PWM_CAPTURE_FILTER_EN
   position_t raw, prev;
   logic raw_v;
   logic [8:0] sum;
   assign sum = {1'b0, raw} + {1'b0, prev} + 9'd1;
   assign vld_n = raw_v;
   always_ff @(posedge clk)
      if (!rst_n) begin
         raw <= '0;
         prev <= '0;
         raw_v <= 1'b0;
         position <= '0;
      end else begin
         raw_v <= done;
         if (done) raw <= stp;
         if (raw_v) begin
            prev <= raw;
            position <= signal_lost ? raw : sum[8:1];
         end
      end
`else
   assign vld_n = done;
   always_ff @(posedge clk)
      if (!rst_n) position <= '0;
      else if (done) position <= stp;
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with scaled-down pulse parameters.
module tb_pwm_capture;
   localparam int MIN_C = 1000, STEP_C = 4, GL_C = 500, MAX_C = 2500, TO_C = 5000;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT = 4;
   int mlv = -1, prev_raw = 0;
`else
   localparam int LAT = 3;
`endif
   typedef struct {bit err; int pos; int at;} exp_t;
   logic clk = 0, rst_n = 0, pwm_in = 0, rst_q = 0;
   logic [7:0] position;
   logic valid, pulse_err, signal_lost;
   int cyc = 0, errors = 0, checks = 0, lv = -1, last_exp = 0;
   bit lost_q = 1;
   exp_t sb[$];
   pwm_capture #(.MIN_CYC(MIN_C), .STEP_CYC(STEP_C), .GLITCH_CYC(GL_C), .MAX_CYC(MAX_C), .TIMEOUT_CYC(TO_C)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .position(position),
      .valid(valid), .pulse_err(pulse_err), .signal_lost(signal_lost)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      rst_q <= rst_n;
   end
   task automatic check(string tag, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask
   function automatic int decode(int w);
      int q;
      q = (w < MIN_C) ? 0 : (w - MIN_C) / STEP_C;
      return (q > 255) ? 255 : q;
   endfunction
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic pulse(int w, int gap = 20);
      exp_t e;
      if (w > MAX_C) e = '{1'b1, last_exp, cyc + MAX_C + 3};
      else if (w < GL_C) e = '{1'b1, last_exp, cyc + w + 3};
      else begin
         e = '{1'b0, decode(w), cyc + w + LAT};
`ifdef PWM_CAPTURE_FILTER_EN
         if (mlv >= 0 && e.at - 1 - mlv < TO_C) e.pos = (e.pos + prev_raw + 1) >> 1;
         prev_raw = decode(w);
         mlv = e.at;
`endif
         last_exp = e.pos;
      end
      sb.push_back(e);
      pwm_in = 1;
      tick(w);
      pwm_in = 0;
      tick(gap);
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      int l;
      bit lm;
      l = lv;
      if (!rst_q) l = -1;
      else if (valid || pulse_err) begin
         if (sb.size() == 0) check("spurious_strobe", int'({valid, pulse_err}), 0);
         else begin
            e = sb.pop_front();
            check("strobe_kind", int'({valid, pulse_err}), e.err ? 1 : 2);
            check("position", int'(position), e.pos);
            check("strobe_cycle", cyc, e.at);
            if (!e.err) l = e.at;
         end
      end
      lm = (l < 0) || (cyc - l >= TO_C);
      if (lm != lost_q || signal_lost !== lm) check("signal_lost", int'(signal_lost), int'(lm));
      lv <= l;
      lost_q <= lm;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
   initial begin
      tick(3);
      check("rst_position", int'(position), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_pulse_err", int'(pulse_err), 0);
      check("rst_signal_lost", int'(signal_lost), 1);
      rst_n = 1;
      tick(5);
      pulse(1500);
      pulse(1000);
      pulse(2000);
      pulse(2400);
      pulse(2019);
      pulse(2020);
      pulse(300);
      pulse(GL_C - 1);
      pulse(GL_C);
      pulse(MAX_C);
      pulse(MAX_C + 1);
      pulse(3000);
      pulse(1500);
      pwm_in = 1;
      tick(400);
      rst_n = 0;
      tick(2);
      rst_n = 1;
`ifdef PWM_CAPTURE_FILTER_EN
      mlv = -1;
`endif
      last_exp = 0;
      tick(300);
      pwm_in = 0;
      tick(20);
      check("rst_mid_position", int'(position), 0);
      pulse(1500);
      pulse(1200, 1);
      pulse(1700);
      tick(TO_C + 50);
      pulse(1000);
      pulse(2000);
      tick(20);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
